mpu_fetcher: RTL and testbench
==============================

Name: mpu_fetcher

Overview:
- Instruction fetch/align unit feeding the MPU decoder.
- Reads 32-bit words from instruction memory into a byte buffer and presents a 48-bit little-endian window at the current PC (i[7:0] = byte at pc).
- Consumes the decoder's instruction size to advance the PC, and the controller's jump request to redirect it.
- Sits between the instruction RAM and the decoder.

Parameters:
- DEPTH, 12, byte buffer capacity; multiple of 4, legal range 8..32.
- WIN, 6, window size in bytes (48-bit instruction max); fixed, not overridable by instantiation.

Ports:
- sys_clk in 1 system clock.
- sys_rst_n in 1 asynchronous active-low reset.
- en in 1 fetch enable; 0 blocks new reads only.
- mem_re out 1 memory read strobe.
- mem_adr out 14 word address (byte address [15:2]).
- mem_dat in 32 read data, valid the cycle after mem_re; byte at word*4 on [7:0].
- i out 48 instruction window, bytes pc..pc+5.
- i_valid out 1 window holds WIN valid bytes.
- pc out 16 byte address of i[7:0].
- adv in 1 consume isize bytes.
- isize in 16 instruction size in bytes (decoder output).
- jmp in 1 redirect to jaddr.
- jaddr in 16 jump target byte address.
- fetch_err out 1 sticky illegal-advance flag.

Behaviour:
- Reset (async, sys_rst_n=0): mem_re=0, mem_adr=0, i=0, i_valid=0, pc=0, fetch_err=0, count=0, inflight=0, skip=0, epoch=0, state=S_RUN.
- State: single run state plus one-bit inflight tracker. "epoch" is a 1-bit tag toggled on every jmp; each read captures the epoch at issue.
- Read issue, registered:
  - mem_re=1 next cycle iff en, !jmp, and count + 4*inflight + 4 <= DEPTH.
  - mem_adr increments after each issue and wraps 0x3fff -> 0x0000.
- Response:
  - In the cycle after mem_re, mem_dat is appended at buffer position count, only if its tag equals the current epoch; otherwise it is dropped.
  - The first accepted word after a jmp drops its low skip bytes (skip = jaddr[1:0]), then skip=0.
- i_valid = (count >= WIN), from registered count. From reset with en=1: reads in cycles 1 and 2, i_valid high in cycle 4.
- adv:
  - Honoured only when i_valid=1 and 1 <= isize <= WIN.
  - Effect: buffer shifts down isize bytes, pc += isize (mod 2^16), count -= isize.
  - adv with i_valid=0 is ignored silently.
  - adv with isize=0 or isize>WIN while i_valid=1 sets fetch_err; pc and buffer unchanged.
- Simultaneous adv and response: shift first, then append at count-isize; count' = count - isize + appended.
- jmp (priority over adv and response in the same cycle):
  - Next cycle: count=0, i_valid=0, pc=jaddr, mem_adr=jaddr[15:2], skip=jaddr[1:0], epoch toggles, fetch_err=0, no mem_re in the jmp cycle.
  - Reads resume the following cycle per the issue rule.
- en=0: no new reads. An in-flight response is still accepted. adv and jmp still work.
- pc wrap: 0xffff + 1 = 0x0000. Fetch continues from mem_adr 0x0000 after 0x3fff.
- Reset mid-fetch: all state cleared; a pending response is ignored (inflight=0).

Optional Feature:
- Macro MPU_FETCH_STATS_EN.
- Defined:
  - Adds output stall_cnt[31:0], counting cycles with en=1 and i_valid=0.
  - Adds output word_cnt[31:0], counting accepted memory words.
  - Both reset to 0, saturate at 0xffffffff, and are not cleared by jmp.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared include mpu_fetch.vh: WIN, byte-count width, isize legal bounds, word/byte address split constants.
- One sub-module, mpu_fetch_buf: DEPTH-byte shift/append buffer with count. Inputs: shift amount, append data, append byte count, append offset, flush. Outputs: window and count.
- Top module holds pc, mem_adr, issue logic, epoch/skip, fetch_err.

Test Plan:
- Reset, en=1, mem words 0x44332211, 0x88776655 at 0,1 -> mem_re cycles 1,2 (adr 0,1); cycle 4 i_valid=1, i=0x665544332211, pc=0.
- Steady state, adv isize=3 -> next cycle pc=3, i[7:0]=0x44; refill keeps count <= 12, never overflows.
- jmp jaddr=0x0107 with read in flight -> stale word dropped, next mem_re adr=0x41; first word yields only byte 0x107; i_valid once 6 bytes held, pc=0x0107.
- jmp and adv same cycle -> jmp wins: pc=jaddr, isize ignored.
- adv isize=0 with i_valid=1 -> fetch_err=1, pc unchanged; subsequent jmp clears it; adv with i_valid=0 -> no change, no error.
- jmp 0xfffe -> mem_adr 0x3fff then 0x0000; after adv isize=3, pc=0x0001.

Source files
------------

// File: rtl/mpu_fetcher_pkg.sv
// Shared constants and types for the MPU instruction fetcher.
// Latency: none (declarations only).
// Backpressure: n/a.
package mpu_fetcher_pkg;

  // Decoder window: 48-bit maximum instruction, fixed.
  localparam int WIN       = 6;
  // Byte-count width: holds 0..32 (largest legal buffer).
  localparam int CNT_W     = 6;
  // Legal instruction sizes, in bytes.
  localparam int ISIZE_MIN = 1;
  localparam int ISIZE_MAX = WIN;
  // Byte address [15:2] is the word address; [1:0] is the byte lane.
  localparam int BADR_LSB  = 2;
  localparam int WADR_W    = 14;

  typedef enum logic [0:0] {
    S_RUN = 1'b0
  } state_e;

  function automatic logic isize_legal(input logic [15:0] s);
    return (s >= 16'(ISIZE_MIN)) && (s <= 16'(ISIZE_MAX));
  endfunction

endpackage

// File: rtl/mpu_fetch_buf.sv
// Byte shift/append buffer: drops shift_i bytes from the bottom, writes app_n_i bytes at app_off_i.
// Latency: 1 cycle, window and count registered.
// Backpressure: none; caller guarantees the append never exceeds DEPTH bytes.
// Ports: clk_i/rst_ni clock and async active-low reset; shift_i, app_dat_i, app_n_i,
//        app_off_i, flush_i control inputs; win_o lowest WIN bytes; cnt_o valid byte count.
module mpu_fetch_buf
  import mpu_fetcher_pkg::*;
#(
  parameter int DEPTH = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [2:0]       shift_i,
  input  logic [31:0]      app_dat_i,
  input  logic [2:0]       app_n_i,
  input  logic [CNT_W-1:0] app_off_i,
  input  logic             flush_i,
  output logic [8*WIN-1:0] win_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int BW = 8 * DEPTH;

  logic [BW-1:0]    buf_q, buf_d;
  logic [BW-1:0]    shifted, app_mask, keep;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q - CNT_W'(shift_i) + CNT_W'(app_n_i);
    shifted  = buf_q >> {shift_i, 3'b000};
    app_mask = ~({BW{1'b1}} << {app_n_i, 3'b000}) << {app_off_i, 3'b000};
    // Bytes at or above the new count are zeroed so stale data never lingers.
    keep     = ~({BW{1'b1}} << {cnt_d, 3'b000});
    buf_d    = ((shifted & ~app_mask)
               | ((BW'(app_dat_i) << {app_off_i, 3'b000}) & app_mask)) & keep;
    if (flush_i) begin
      buf_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign win_o = buf_q[8*WIN-1:0];
  assign cnt_o = cnt_q;

endmodule

// File: rtl/mpu_fetcher.sv
// Instruction fetch/align: streams 32-bit words into a byte buffer, presents a 48-bit window at pc.
// Latency: read issued 1 cycle after decision, data 1 cycle later, window valid once 6 bytes held.
// Backpressure: reads stop when buffer plus in-flight word would exceed DEPTH; adv only when i_valid.
// Ports: sys_clk/sys_rst_n; en fetch enable; mem_re/mem_adr/mem_dat instruction RAM;
//        i/i_valid/pc window to decoder; adv/isize consume; jmp/jaddr redirect; fetch_err sticky.
// Optional MPU_FETCH_STATS_EN: adds stall_cnt and word_cnt saturating counters.
module mpu_fetcher
  import mpu_fetcher_pkg::*;
#(
  parameter int DEPTH = 12
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              en,
  output logic              mem_re,
  output logic [WADR_W-1:0] mem_adr,
  input  logic [31:0]       mem_dat,
  output logic [8*WIN-1:0]  i,
  output logic              i_valid,
  output logic [15:0]       pc,
  input  logic              adv,
  input  logic [15:0]       isize,
  input  logic              jmp,
  input  logic [15:0]       jaddr,
  output logic              fetch_err
`ifdef MPU_FETCH_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       word_cnt
`endif
);

  state_e            state_q, state_d;
  logic [15:0]       pc_q, pc_d;
  logic [WADR_W-1:0] adr_q, adr_d;
  logic [1:0]        skip_q, skip_d;
  logic              epoch_q, epoch_d;
  logic              err_q, err_d;
  logic              re_q, re_d;
  logic              re_ep_q;           // epoch tag of the read on the bus
  logic              infl_q, infl_ep_q; // response due this cycle and its tag

  logic [CNT_W-1:0]  cnt, off;
  logic [CNT_W:0]    cnt_nxt;
  logic [2:0]        shift, app_n;
  logic [31:0]       app_dat;
  logic              adv_ok, acc;

  always_comb begin
    state_d = S_RUN;
    pc_d    = pc_q;
    adr_d   = adr_q;
    skip_d  = skip_q;
    epoch_d = epoch_q;
    err_d   = err_q;
    re_d    = 1'b0;
    shift   = '0;
    app_n   = '0;
    cnt_nxt = '0;
    adv_ok  = adv && i_valid && isize_legal(isize);
    // A response is kept only if no jump happened since it was issued.
    acc     = infl_q && (infl_ep_q == epoch_q);
    app_dat = mem_dat >> {skip_q, 3'b000};
    if (jmp) begin
      pc_d    = jaddr;
      adr_d   = jaddr[15:BADR_LSB];
      skip_d  = jaddr[BADR_LSB-1:0];
      epoch_d = ~epoch_q;
      err_d   = 1'b0;
    end else begin
      if (adv_ok) begin
        shift = isize[2:0];
        pc_d  = pc_q + isize;
      end else if (adv && i_valid) begin
        err_d = 1'b1;
      end
      if (acc) begin
        app_n  = 3'd4 - {1'b0, skip_q};
        skip_d = '0;
      end
      if (re_q) adr_d = adr_q + WADR_W'(1);
      // Issue rule uses the post-update count plus the word already on the bus.
      cnt_nxt = (CNT_W+1)'(cnt) - (CNT_W+1)'(shift) + (CNT_W+1)'(app_n);
      re_d    = (state_q == S_RUN) && en
                && (int'(cnt_nxt) + (re_q ? 4 : 0) + 4 <= DEPTH);
    end
    off = cnt - CNT_W'(shift);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_RUN;
      pc_q      <= '0;
      adr_q     <= '0;
      skip_q    <= '0;
      epoch_q   <= 1'b0;
      err_q     <= 1'b0;
      re_q      <= 1'b0;
      re_ep_q   <= 1'b0;
      infl_q    <= 1'b0;
      infl_ep_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      adr_q     <= adr_d;
      skip_q    <= skip_d;
      epoch_q   <= epoch_d;
      err_q     <= err_d;
      re_q      <= re_d;
      re_ep_q   <= epoch_q;
      infl_q    <= re_q;
      infl_ep_q <= re_ep_q;
    end
  end

  mpu_fetch_buf #(.DEPTH(DEPTH)) u_buf (
    .clk_i     (sys_clk),
    .rst_ni    (sys_rst_n),
    .shift_i   (shift),
    .app_dat_i (app_dat),
    .app_n_i   (app_n),
    .app_off_i (off),
    .flush_i   (jmp),
    .win_o     (i),
    .cnt_o     (cnt)
  );

  assign i_valid   = (cnt >= CNT_W'(WIN));
  assign mem_re    = re_q;
  assign mem_adr   = adr_q;
  assign pc        = pc_q;
  assign fetch_err = err_q;

`ifdef MPU_FETCH_STATS_EN
  logic [31:0] stall_q, word_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stall_q <= '0;
      word_q  <= '0;
    end else begin
      if (en && !i_valid && (stall_q != 32'hffff_ffff)) stall_q <= stall_q + 32'd1;
      if ((app_n != 3'd0) && (word_q != 32'hffff_ffff)) word_q <= word_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign word_cnt  = word_q;
`else
  // Statistics counters not built.
`endif

endmodule

// File: tb/tb_mpu_fetcher.sv
module tb_mpu_fetcher;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        en;
  logic        mem_re;
  logic [13:0] mem_adr;
  logic [31:0] mem_dat   = '0;
  logic [47:0] i;
  logic        i_valid;
  logic [15:0] pc;
  logic        adv;
  logic [15:0] isize;
  logic        jmp;
  logic [15:0] jaddr;
  logic        fetch_err;

  int n_tests = 0;
  int n_fail  = 0;
  int szs[6]  = '{6, 1, 4, 6, 2, 5};
  logic [15:0] pcm;

  always #5 sys_clk = ~sys_clk;

  mpu_fetcher #(.DEPTH(12)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (en),
    .mem_re    (mem_re),
    .mem_adr   (mem_adr),
    .mem_dat   (mem_dat),
    .i         (i),
    .i_valid   (i_valid),
    .pc        (pc),
    .adv       (adv),
    .isize     (isize),
    .jmp       (jmp),
    .jaddr     (jaddr),
    .fetch_err (fetch_err)
  );

  // Memory content: byte at address a = ((a[7:0]+1)*0x11 mod 256) ^ a[15:8].
  function automatic logic [7:0] bval(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0] + 8'd1;
    return 8'(lo * 8'h11) ^ a[15:8];
  endfunction

  function automatic logic [31:0] wval(input logic [13:0] w);
    return {bval({w, 2'd3}), bval({w, 2'd2}), bval({w, 2'd1}), bval({w, 2'd0})};
  endfunction

  function automatic logic [47:0] winval(input logic [15:0] p);
    logic [47:0] r;
    r = '0;
    for (int k = 0; k < 6; k++) r[8*k +: 8] = bval(p + 16'(k));
    return r;
  endfunction

  always @(posedge sys_clk) if (mem_re) mem_dat <= wval(mem_adr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!i_valid && k < 30) begin
      step();
      k++;
    end
    chk(tag, i_valid, 1'b1);
  endtask

  task automatic wait_re(input string tag);
    int k;
    k = 0;
    while (!mem_re && k < 30) begin
      step();
      k++;
    end
    chk(tag, mem_re, 1'b1);
  endtask

  task automatic do_adv(input logic [15:0] n);
    adv = 1'b1; isize = n;
    step();
    adv = 1'b0;
  endtask

  task automatic do_jmp(input logic [15:0] a);
    jmp = 1'b1; jaddr = a;
    step();
    jmp = 1'b0;
  endtask

  // Reset released just after a rising edge; the next edge is cycle 1.
  task automatic start_seq(input string tag);
    step();
    sys_rst_n = 1'b1;
    step(); chk({tag, "_c1_re"}, mem_re, 1'b1); chk({tag, "_c1_adr"}, mem_adr, 14'h0);
    step(); chk({tag, "_c2_re"}, mem_re, 1'b1); chk({tag, "_c2_adr"}, mem_adr, 14'h1);
    step(); chk({tag, "_c3_vld"}, i_valid, 1'b0);
    step(); chk({tag, "_c4_vld"}, i_valid, 1'b1);
    chk({tag, "_c4_i"}, i, 48'h665544332211);
    chk({tag, "_c4_pc"}, pc, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    en = 1'b1; adv = 1'b0; isize = '0; jmp = 1'b0; jaddr = '0;
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst_re", mem_re, 1'b0);
    chk("rst_adr", mem_adr, 14'h0);
    chk("rst_i", i, 48'h0);
    chk("rst_vld", i_valid, 1'b0);
    chk("rst_pc", pc, 16'h0);
    chk("rst_err", fetch_err, 1'b0);
    step();
    start_seq("boot");

    // Simple advance.
    do_adv(16'd3);
    chk("adv3_pc", pc, 16'h0003);
    chk("adv3_b0", i[7:0], 8'h44);
    repeat (4) step();
    chk("adv3_i", i, 48'h998877665544);
    chk("adv3_vld", i_valid, 1'b1);

    // Steady-state streaming with mixed sizes.
    pcm = 16'h0003;
    for (int n = 0; n < 6; n++) begin
      wait_valid("st_vld");
      chk("st_pc", pc, pcm);
      chk("st_i", i, winval(pcm));
      do_adv(16'(szs[n]));
      pcm = pcm + 16'(szs[n]);
    end

    // Jump while a read is on the bus; the stale word must be dropped.
    wait_re("jf_find");
    do_jmp(16'h0107);
    chk("jf_pc", pc, 16'h0107);
    chk("jf_vld", i_valid, 1'b0);
    chk("jf_re0", mem_re, 1'b0);
    chk("jf_adr0", mem_adr, 14'h041);
    step();
    chk("jf_re1", mem_re, 1'b1);
    chk("jf_adr1", mem_adr, 14'h041);
    wait_valid("jf_vld2");
    chk("jf_i", i, 48'hDCCDBAAB9889);
    chk("jf_pc2", pc, 16'h0107);

    // Jump and advance together: jump wins.
    jmp = 1'b1; jaddr = 16'h0200; adv = 1'b1; isize = 16'd2;
    step();
    jmp = 1'b0; adv = 1'b0;
    chk("ja_pc", pc, 16'h0200);
    chk("ja_vld", i_valid, 1'b0);
    // Advance while window invalid: ignored, no error.
    do_adv(16'd3);
    chk("iv_pc", pc, 16'h0200);
    chk("iv_err", fetch_err, 1'b0);
    wait_valid("ja_vld2");
    chk("ja_i", i, 48'h645746312013);

    // Illegal sizes.
    do_adv(16'd0);
    chk("e0_err", fetch_err, 1'b1);
    chk("e0_pc", pc, 16'h0200);
    do_adv(16'd7);
    chk("e7_err", fetch_err, 1'b1);
    chk("e7_pc", pc, 16'h0200);
    chk("e7_i", i, 48'h645746312013);

    // Jump near the top of memory: clears the error and wraps.
    do_jmp(16'hfffe);
    chk("w_err", fetch_err, 1'b0);
    chk("w_adr0", mem_adr, 14'h3fff);
    chk("w_re0", mem_re, 1'b0);
    step();
    chk("w_re1", mem_re, 1'b1);
    chk("w_adr1", mem_adr, 14'h3fff);
    step();
    chk("w_re2", mem_re, 1'b1);
    chk("w_adr2", mem_adr, 14'h0000);
    wait_valid("w_vld");
    chk("w_i", i, 48'h44332211FF10);
    chk("w_pc", pc, 16'hfffe);
    do_adv(16'd3);
    chk("w_pc2", pc, 16'h0001);
    chk("w_b0", i[7:0], 8'h22);
    wait_valid("w_vld2");
    chk("w_i2", i, 48'h776655443322);

    // Fetch disabled: no reads.
    do_adv(16'd6);
    en = 1'b0;
    step();
    chk("en0_re1", mem_re, 1'b0);
    step();
    chk("en0_re2", mem_re, 1'b0);

    // Reset in the middle of a fetch.
    en = 1'b1;
    wait_valid("rm_vld");
    do_adv(16'd6);
    wait_re("rm_find");
    sys_rst_n = 1'b0;
    #1;
    chk("rm_pc", pc, 16'h0);
    chk("rm_vld", i_valid, 1'b0);
    chk("rm_re", mem_re, 1'b0);
    chk("rm_i", i, 48'h0);
    start_seq("rm");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
